// File: rtl/vision_input_conditioner.sv
// vision_input_conditioner
// Moves the raw vision-pipeline outputs into the system clock domain and
// turns them into game-logic events. The raw outputs are synchronised, and one
// frame event is detected per rising edge of the valid flag. Lane changes are
// debounced over several agreeing frames. Each action flag is stretched into a
// minimum-length hold that is extended until the player has landed.
module vision_input_conditioner #(
  parameter int NUM_ACTIONS        = 2,
  parameter int HOLD_CYCLES        = 48_750_000,
  parameter int TIMER_WIDTH        = 30,
  parameter int LANE_WIDTH         = 2,
  parameter int LANE_RESET         = 1,
  parameter int LANE_STABLE_FRAMES = 3,
  parameter int QUAD_WIDTH         = 9,
  parameter int SYNC_STAGES        = 2
) (
  input  logic                   system_clock_in,
  input  logic                   system_reset_n,
  input  logic [LANE_WIDTH-1:0]  lane_raw,
  input  logic [NUM_ACTIONS-1:0] action_raw,
  input  logic [QUAD_WIDTH-1:0]  quadrants_raw,
  input  logic                   vision_data_valid_raw,
  output logic [LANE_WIDTH-1:0]  lane_synced,
  output logic [NUM_ACTIONS-1:0] action_synced,
  output logic                   frame_strobe,
  output logic [LANE_WIDTH-1:0]  lane,
  output logic                   lane_changed,
  output logic [NUM_ACTIONS-1:0] action,
  output logic [NUM_ACTIONS-1:0] action_start,
  output logic [QUAD_WIDTH-1:0]  quadrants
);

  // All foreign-domain inputs travel through one shared chain so that every
  // field sees the same latency.
  localparam int SYNC_W = LANE_WIDTH + NUM_ACTIONS + QUAD_WIDTH + 1;
  localparam int CNT_W  = $clog2(LANE_STABLE_FRAMES + 1);

  localparam logic [CNT_W-1:0]       CNT_TARGET = CNT_W'(LANE_STABLE_FRAMES);
  localparam logic [CNT_W-1:0]       CNT_ONE    = CNT_W'(1);
  localparam logic [TIMER_WIDTH-1:0] HOLD_LOAD  = TIMER_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [LANE_WIDTH-1:0]  LANE_INIT  = LANE_WIDTH'(LANE_RESET);

  typedef enum logic [1:0] {
    ACT_IDLE,
    ACT_HOLD,
    ACT_WAIT_LAND
  } actState_e;

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  logic [SYNC_W-1:0] syncChain_q [SYNC_STAGES];
  logic [SYNC_W-1:0] rawBus;
  logic [SYNC_W-1:0] syncedBus;

  logic [LANE_WIDTH-1:0]  laneSync;
  logic [NUM_ACTIONS-1:0] actionSync;
  logic [QUAD_WIDTH-1:0]  quadSync;
  logic                   validSync;

  assign rawBus = {vision_data_valid_raw, quadrants_raw, action_raw, lane_raw};

  // Shift every raw sample through SYNC_STAGES flops before anything uses it.
  always_ff @(posedge system_clock_in or negedge system_reset_n) begin
    if (!system_reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        syncChain_q[s] <= '0;
      end
    end else begin
      syncChain_q[0] <= rawBus;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        syncChain_q[s] <= syncChain_q[s-1];
      end
    end
  end

  assign syncedBus  = syncChain_q[SYNC_STAGES-1];
  assign laneSync   = syncedBus[LANE_WIDTH-1:0];
  assign actionSync = syncedBus[LANE_WIDTH +: NUM_ACTIONS];
  assign quadSync   = syncedBus[LANE_WIDTH + NUM_ACTIONS +: QUAD_WIDTH];
  assign validSync  = syncedBus[SYNC_W-1];

  assign lane_synced   = laneSync;
  assign action_synced = actionSync;

  // ---------------------------------------------------------------------------
  // Frame detection and per-frame capture
  // ---------------------------------------------------------------------------
  logic                  validDelay_q;
  logic                  frame;
  logic                  frameStrobe_q;
  logic [QUAD_WIDTH-1:0] quadrants_q;

  // A frame is the rising edge of the synchronised valid level, so a long
  // valid pulse still counts as a single frame.
  assign frame = validSync & ~validDelay_q;

  // Remember the previous valid level, pulse the strobe and latch the
  // quadrant bitmap once per frame.
  always_ff @(posedge system_clock_in or negedge system_reset_n) begin
    if (!system_reset_n) begin
      validDelay_q  <= 1'b0;
      frameStrobe_q <= 1'b0;
      quadrants_q   <= '0;
    end else begin
      validDelay_q  <= validSync;
      frameStrobe_q <= frame;
      if (frame) begin
        quadrants_q <= quadSync;
      end
    end
  end

  assign frame_strobe = frameStrobe_q;
  assign quadrants    = quadrants_q;

  // ---------------------------------------------------------------------------
  // Lane debounce filter
  // ---------------------------------------------------------------------------
  logic [LANE_WIDTH-1:0] lane_q, lane_d;
  logic [LANE_WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  laneChanged_q, laneChanged_d;
  logic [CNT_W-1:0]      cntNext;

  // Count consecutive frames that agree on a new lane. Seeing the committed
  // lane again discards the run. A different candidate restarts the run at
  // one.
  always_comb begin
    lane_d        = lane_q;
    cand_d        = cand_q;
    cnt_d         = cnt_q;
    laneChanged_d = 1'b0;
    cntNext       = '0;
    if (frame) begin
      if (laneSync == lane_q) begin
        cnt_d = '0;
      end else begin
        if ((laneSync == cand_q) && (cnt_q != '0)) begin
          cntNext = cnt_q + CNT_ONE;
        end else begin
          cand_d  = laneSync;
          cntNext = CNT_ONE;
        end
        if (cntNext == CNT_TARGET) begin
          lane_d        = laneSync;
          cnt_d         = '0;
          laneChanged_d = 1'b1;
        end else begin
          cnt_d = cntNext;
        end
      end
    end
  end

  // Register the filter state. The committed lane restarts at LANE_RESET.
  always_ff @(posedge system_clock_in or negedge system_reset_n) begin
    if (!system_reset_n) begin
      lane_q        <= LANE_INIT;
      cand_q        <= '0;
      cnt_q         <= '0;
      laneChanged_q <= 1'b0;
    end else begin
      lane_q        <= lane_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      laneChanged_q <= laneChanged_d;
    end
  end

  assign lane         = lane_q;
  assign lane_changed = laneChanged_q;

  // ---------------------------------------------------------------------------
  // Action stretchers, one independent FSM and timer per channel
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_ACTIONS; i++) begin : gAction
    actState_e              state_q, state_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic                   start_q, start_d;

    // Idle channels arm on a frame that carries the action. A hold lasts
    // HOLD_CYCLES. After that, the channel waits until the action flag has
    // dropped. Frames are ignored while the channel is busy.
    always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      start_d = 1'b0;
      case (state_q)
        ACT_IDLE: begin
          if (frame && actionSync[i]) begin
            state_d = ACT_HOLD;
            timer_d = HOLD_LOAD;
            start_d = 1'b1;
          end
        end
        ACT_HOLD: begin
          if (timer_q == '0) begin
            state_d = actionSync[i] ? ACT_WAIT_LAND : ACT_IDLE;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        ACT_WAIT_LAND: begin
          if (!actionSync[i]) begin
            state_d = ACT_IDLE;
          end
        end
        default: begin
          state_d = ACT_IDLE;
          timer_d = '0;
        end
      endcase
    end

    // Hold the channel state, the timer and the start pulse.
    always_ff @(posedge system_clock_in or negedge system_reset_n) begin
      if (!system_reset_n) begin
        state_q <= ACT_IDLE;
        timer_q <= '0;
        start_q <= 1'b0;
      end else begin
        state_q <= state_d;
        timer_q <= timer_d;
        start_q <= start_d;
      end
    end

    // The action level comes straight from registered state, so reset clears
    // it at once.
    assign action[i]       = (state_q != ACT_IDLE);
    assign action_start[i] = start_q;
  end

endmodule

// File: tb/tb_vision_input_conditioner.sv
// Directed testbench for vision_input_conditioner. It uses short holds so
// that each scenario fits in a few dozen clock cycles.
module tb_vision_input_conditioner;

  localparam int NA  = 2;
  localparam int HC  = 8;
  localparam int TW  = 30;
  localparam int LW  = 2;
  localparam int LR  = 1;
  localparam int LSF = 3;
  localparam int QW  = 9;
  localparam int SS  = 2;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic [LW-1:0] laneRaw = '0;
  logic [NA-1:0] actionRaw = '0;
  logic [QW-1:0] quadRaw = '0;
  logic          validRaw = 1'b0;

  logic [LW-1:0] laneSynced;
  logic [NA-1:0] actionSynced;
  logic          frameStrobe;
  logic [LW-1:0] laneOut;
  logic          laneChanged;
  logic [NA-1:0] actionOut;
  logic [NA-1:0] actionStart;
  logic [QW-1:0] quadOut;

  int checks = 0;
  int failures = 0;

  vision_input_conditioner #(
    .NUM_ACTIONS(NA), .HOLD_CYCLES(HC), .TIMER_WIDTH(TW), .LANE_WIDTH(LW),
    .LANE_RESET(LR), .LANE_STABLE_FRAMES(LSF), .QUAD_WIDTH(QW), .SYNC_STAGES(SS)
  ) dut (
    .system_clock_in(clk),
    .system_reset_n(rstN),
    .lane_raw(laneRaw),
    .action_raw(actionRaw),
    .quadrants_raw(quadRaw),
    .vision_data_valid_raw(validRaw),
    .lane_synced(laneSynced),
    .action_synced(actionSynced),
    .frame_strobe(frameStrobe),
    .lane(laneOut),
    .lane_changed(laneChanged),
    .action(actionOut),
    .action_start(actionStart),
    .quadrants(quadOut)
  );

  // 10 ns system clock
  always #5 clk = ~clk;

  // Advance one clock edge. Outputs are sampled 1 ns after that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Keep the inputs quiet for n cycles.
  task automatic idle(input int n);
    validRaw  = 1'b0;
    actionRaw = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // One frame: valid high for three edges, then low for three edges.
  task automatic sendFrame(input logic [LW-1:0] l, input logic [NA-1:0] a,
                           input logic [QW-1:0] q, output int strobes,
                           output int changes);
    strobes   = 0;
    changes   = 0;
    laneRaw   = l;
    actionRaw = a;
    quadRaw   = q;
    validRaw  = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (frameStrobe) strobes++;
      if (laneChanged) changes++;
      if (k == 3) validRaw = 1'b0;
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    laneRaw = '0; actionRaw = '0; quadRaw = '0; validRaw = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (laneOut !== 2'd1) begin failures++; $display("[TB] FAIL reset_lane got=%0d exp=1", laneOut); end
    checks++; if (actionOut !== 2'b00) begin failures++; $display("[TB] FAIL reset_action got=%b exp=00", actionOut); end
    checks++; if (quadOut !== 9'h000) begin failures++; $display("[TB] FAIL reset_quad got=%h exp=000", quadOut); end
    checks++; if ({frameStrobe, laneChanged, actionStart} !== 4'b0000) begin failures++; $display("[TB] FAIL reset_pulses got=%b exp=0000", {frameStrobe, laneChanged, actionStart}); end
    rstN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (laneOut !== 2'd1 || actionOut !== 2'b00 || frameStrobe !== 1'b0 || laneChanged !== 1'b0) begin
        failures++;
        $display("[TB] FAIL idle_after_reset cyc=%0d got lane=%0d act=%b fs=%b lc=%b exp lane=1 act=00 fs=0 lc=0",
                 i, laneOut, actionOut, frameStrobe, laneChanged);
      end
    end
    // Start a hold on channel 0, then pull reset in the middle of it.
    actionRaw = 2'b01;
    laneRaw   = 2'd1;
    validRaw  = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (actionOut !== 2'b01) begin failures++; $display("[TB] FAIL hold_before_reset got=%b exp=01", actionOut); end
    rstN = 1'b0;
    #2;
    checks++; if (actionOut !== 2'b00) begin failures++; $display("[TB] FAIL async_reset_drop got=%b exp=00", actionOut); end
    tick(); tick();
    validRaw = 1'b0; actionRaw = '0;
    rstN = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (actionOut !== 2'b00 || laneOut !== 2'd1) begin failures++; $display("[TB] FAIL post_reset got act=%b lane=%0d exp act=00 lane=1", actionOut, laneOut); end
  endtask

  task automatic test_frame();
    int strobes;
    strobes  = 0;
    laneRaw  = 2'd1;
    quadRaw  = 9'h1A5;
    validRaw = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (frameStrobe) strobes++;
      checks++;
      if (frameStrobe !== (k == 3)) begin failures++; $display("[TB] FAIL frame_strobe k=%0d got=%b exp=%b", k, frameStrobe, (k == 3)); end
      checks++;
      if (quadOut !== ((k >= 3) ? 9'h1A5 : 9'h000)) begin failures++; $display("[TB] FAIL quadrants k=%0d got=%h exp=%h", k, quadOut, (k >= 3) ? 9'h1A5 : 9'h000); end
    end
    validRaw = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (frameStrobe) strobes++;
    end
    checks++; if (strobes != 1) begin failures++; $display("[TB] FAIL frame_count got=%0d exp=1", strobes); end
    quadRaw = '0;
  endtask

  task automatic test_lane();
    logic [LW-1:0] seqA [3] = '{2'd2, 2'd2, 2'd1};
    logic [LW-1:0] seqB [6] = '{2'd2, 2'd2, 2'd0, 2'd2, 2'd2, 2'd2};
    logic [LW-1:0] expB [6] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    int            chgB [6] = '{0, 0, 0, 0, 0, 1};
    int strobes, changes;
    for (int f = 0; f < 3; f++) begin
      sendFrame(seqA[f], 2'b00, 9'h000, strobes, changes);
      checks++; if (laneOut !== 2'd1 || changes != 0) begin failures++; $display("[TB] FAIL lane_reset_run f=%0d got lane=%0d chg=%0d exp lane=1 chg=0", f, laneOut, changes); end
    end
    for (int f = 0; f < 6; f++) begin
      sendFrame(seqB[f], 2'b00, 9'h000, strobes, changes);
      checks++; if (strobes != 1) begin failures++; $display("[TB] FAIL lane_frame_strobes f=%0d got=%0d exp=1", f, strobes); end
      checks++; if (laneOut !== expB[f] || changes != chgB[f]) begin failures++; $display("[TB] FAIL lane_filter f=%0d got lane=%0d chg=%0d exp lane=%0d chg=%0d", f, laneOut, changes, expB[f], chgB[f]); end
    end
  endtask

  task automatic test_action_hold();
    logic [NA-1:0] expAct, expStart;
    laneRaw   = 2'd2;
    actionRaw = 2'b01;
    validRaw  = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      expAct   = {1'b0, (k >= 3 && k <= 10)};
      expStart = (k == 3) ? 2'b01 : 2'b00;
      checks++; if (actionOut !== expAct) begin failures++; $display("[TB] FAIL hold_action k=%0d got=%b exp=%b", k, actionOut, expAct); end
      checks++; if (actionStart !== expStart) begin failures++; $display("[TB] FAIL hold_start k=%0d got=%b exp=%b", k, actionStart, expStart); end
      checks++; if (frameStrobe !== (k == 3 || k == 7)) begin failures++; $display("[TB] FAIL hold_strobe k=%0d got=%b exp=%b", k, frameStrobe, (k == 3 || k == 7)); end
      if (k == 3) begin validRaw = 1'b0; actionRaw = 2'b00; end
      if (k == 4) begin validRaw = 1'b1; actionRaw = 2'b01; end
      if (k == 5) actionRaw = 2'b00;
      if (k == 7) validRaw = 1'b0;
    end
  endtask

  task automatic test_wait_land();
    logic [NA-1:0] expAct, expStart, expSync;
    laneRaw   = 2'd2;
    actionRaw = 2'b10;
    validRaw  = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      expAct   = {(k >= 3 && k <= 25), 1'b0};
      expStart = (k == 3) ? 2'b10 : 2'b00;
      expSync  = (k >= 2 && k <= 24) ? 2'b10 : 2'b00;
      checks++; if (actionOut !== expAct) begin failures++; $display("[TB] FAIL land_action k=%0d got=%b exp=%b", k, actionOut, expAct); end
      checks++; if (actionStart !== expStart) begin failures++; $display("[TB] FAIL land_start k=%0d got=%b exp=%b", k, actionStart, expStart); end
      checks++; if (actionSynced !== expSync) begin failures++; $display("[TB] FAIL land_synced k=%0d got=%b exp=%b", k, actionSynced, expSync); end
      if (k == 3) validRaw = 1'b0;
      if (k == 23) actionRaw = 2'b00;
    end
  endtask

  task automatic test_rearm();
    logic [NA-1:0] expAct, expStart;
    laneRaw   = 2'd2;
    actionRaw = 2'b01;
    validRaw  = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      expAct   = {1'b0, ((k >= 3 && k <= 13) || (k >= 18 && k <= 25))};
      expStart = (k == 3 || k == 18) ? 2'b01 : 2'b00;
      checks++; if (actionOut !== expAct) begin failures++; $display("[TB] FAIL rearm_action k=%0d got=%b exp=%b", k, actionOut, expAct); end
      checks++; if (actionStart !== expStart) begin failures++; $display("[TB] FAIL rearm_start k=%0d got=%b exp=%b", k, actionStart, expStart); end
      checks++; if (frameStrobe !== (k == 3 || k == 11 || k == 18)) begin failures++; $display("[TB] FAIL rearm_strobe k=%0d got=%b exp=%b", k, frameStrobe, (k == 3 || k == 11 || k == 18)); end
      if (k == 3) validRaw = 1'b0;
      if (k == 8) validRaw = 1'b1;
      if (k == 11) begin validRaw = 1'b0; actionRaw = 2'b00; end
      if (k == 15) begin validRaw = 1'b1; actionRaw = 2'b01; end
      if (k == 18) begin validRaw = 1'b0; actionRaw = 2'b00; end
    end
  endtask

  // Run every scenario in order, then print the summary.
  initial begin
    test_reset();
    idle(5);
    test_frame();
    idle(5);
    test_lane();
    idle(5);
    test_action_hold();
    idle(5);
    test_wait_land();
    idle(5);
    test_rearm();
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vision_input_conditioner.md
# vision_input_conditioner

Parametrised conditioner between the vision pipeline (pixel-clock domain) and game logic on `system_clock_in`. It synchronises the raw vision outputs and detects one frame event per rising edge of the valid flag. Lane changes are committed only after N consecutive agreeing frames. Each of `NUM_ACTIONS` action channels (jump, duck, …) is stretched into a minimum-duration hold with a wait-to-land extension.

## Interface
- `NUM_ACTIONS`, 2, number of independent action channels (bit 0 = jump).
- `HOLD_CYCLES`, 48_750_000, minimum action-high duration in clocks (≥1).
- `TIMER_WIDTH`, 30, hold-timer width; must hold `HOLD_CYCLES-1`.
- `LANE_WIDTH`, 2, lane code width.
- `LANE_RESET`, 1, committed lane after reset.
- `LANE_STABLE_FRAMES`, 3, consecutive frames required to commit a lane change (≥1).
- `QUAD_WIDTH`, 9, quadrant bitmap width.
- `SYNC_STAGES`, 2, synchroniser depth (≥2).
- `system_clock_in` in 1: system clock, 65 MHz.
- `system_reset_n` in 1: asynchronous, active-low reset.
- `lane_raw` in `LANE_WIDTH`: lane from vision, foreign domain.
- `action_raw` in `NUM_ACTIONS`: per-channel action flags, foreign domain.
- `quadrants_raw` in `QUAD_WIDTH`: quadrant bitmap, foreign domain.
- `vision_data_valid_raw` in 1: frame-data-valid level, foreign domain.
- `lane_synced` out `LANE_WIDTH`: synchroniser output, unfiltered.
- `action_synced` out `NUM_ACTIONS`: synchroniser output, unfiltered.
- `frame_strobe` out 1: one-cycle pulse per detected frame.
- `lane` out `LANE_WIDTH`: committed lane.
- `lane_changed` out 1: one-cycle pulse when `lane` changes.
- `action` out `NUM_ACTIONS`: stretched action levels.
- `action_start` out `NUM_ACTIONS`: one-cycle pulse on entry to HOLD.
- `quadrants` out `QUAD_WIDTH`: quadrant bitmap captured at the last frame.

## Operation
- All raw inputs pass through `SYNC_STAGES` flops. The last stage drives `*_synced`.
- `frame` = `valid_synced & ~valid_synced_d`, where `valid_synced_d` is a one-flop delay. A valid level held for many cycles yields exactly one frame.
- On each `frame` edge:
  - `quadrants <= quadrants_synced`
  - `frame_strobe <= 1`; otherwise `frame_strobe` is 0.
- Lane filter: candidate register `cand` and count `cnt` (width ≥ clog2(`LANE_STABLE_FRAMES`+1)). Evaluated only on `frame`:
  - `lane_synced == lane`: `cnt <= 0`.
  - `lane_synced == cand` and `cnt != 0`: `cnt <= cnt+1`.
  - Otherwise: `cand <= lane_synced`, `cnt <= 1`.
  - When the new count equals `LANE_STABLE_FRAMES`: `lane <= lane_synced`, `cnt <= 0`, `lane_changed` pulses. With `LANE_STABLE_FRAMES=1` the lane commits on the first differing frame.
- Action channel i FSM (IDLE, HOLD, WAIT_LAND), independent per channel, with its own `TIMER_WIDTH` timer:
  - IDLE: `action[i]=0`. On `frame & action_synced[i]`: go to HOLD, `timer <= HOLD_CYCLES-1`, `action[i] <= 1`, `action_start[i]` pulses.
  - HOLD: `action[i]=1`; timer decrements every cycle. Frames are ignored. At `timer==0`: if `action_synced[i]==0` go to IDLE, else go to WAIT_LAND.
  - WAIT_LAND: `action[i]=1`. On the first cycle with `action_synced[i]==0` (not frame-gated), go to IDLE.
  - A HOLD/WAIT_LAND→IDLE transition on the same edge as a `frame` does not start a new hold. Re-arming requires a later frame.
- Timer arithmetic is unsigned and never underflows (decrements only when nonzero in HOLD).

## Timing
- Reset (async assert, sync deassert by system):
  - All sync flops, `valid_synced_d`, `frame_strobe`, `lane_changed`, `action`, `action_start`, `quadrants`, `cand`, `cnt` and timers = 0.
  - `lane = LANE_RESET`; all FSMs in IDLE.
  - Reset asserted mid-hold drops `action` immediately.
- Let edge 1 be the first clock edge sampling `vision_data_valid_raw=1` after it was low. `frame` is true before edge `SYNC_STAGES+1`. On edge `SYNC_STAGES+1`, `frame_strobe`, `quadrants`, `lane`/`lane_changed` and `action`/`action_start` all update together.
- `action[i]` stays high exactly `HOLD_CYCLES` cycles if `action_synced[i]` is low at timer expiry. Otherwise it falls one edge after `action_synced[i]` is first seen low.
- All pulse outputs are exactly one cycle wide. No output is combinational from inputs.

## Test plan
Bench parameters: `HOLD_CYCLES=8`, `LANE_STABLE_FRAMES=3`, `SYNC_STAGES=2`, `LANE_RESET=1`.
- Reset, then idle inputs → `lane=1`, `action=0`, `quadrants=0`, no pulses. Assert reset mid-HOLD → `action` drops to 0 without a clock.
- Valid held high 20 cycles with `quadrants_raw=9'h1A5` → exactly one `frame_strobe`, on edge 3; `quadrants=9'h1A5` from edge 3.
- `lane_raw` = 2, 2, 0, 2, 2, 2 over six frames → `lane` stays 1 until the sixth frame, then becomes 2 with a single `lane_changed` pulse. A frame with `lane_raw=1` resets `cnt`.
- `action_raw[0]` high for one frame then low → `action[0]` high exactly 8 cycles, one `action_start[0]` pulse. Frames with `action_raw[0]=1` during HOLD produce no extra start.
- `action_raw[1]` held high 20 cycles after start → `action[1]` stays high through WAIT_LAND and falls one edge after `action_synced[1]` goes low. `action[0]` is unaffected.
- Frame with `action_raw[0]=1` arriving on the exact edge HOLD→IDLE expires → no new hold. The next frame starts one.
